ssio_sdr_in_framer: RTL and testbench

SSIO_SDR_IN_FRAMER -- requirements
Module: ssio_sdr_in_framer

---
 rtl/ssio_sdr_in_framer.sv | 147 ++++++++++++++
 tb/tb_ssio_sdr_in_framer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ssio_sdr_in_framer.sv
// SDR source-synchronous input: pin capture, fixed-latency delay line and
// frame delimiting (sof/eof/length/runt/frame count) from the data-valid flag.
module ssio_sdr_in_framer #(
  parameter int WIDTH      = 8,
  parameter int PIPE_DEPTH = 2,
  parameter int MIN_LEN    = 4,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     input_d,
  input  logic                 input_dv,
  output logic                 output_clk,
  output logic [WIDTH-1:0]     output_q,
  output logic                 output_dv,
  output logic                 output_sof,
  output logic                 output_eof,
  output logic [LEN_WIDTH-1:0] output_len,
  output logic                 output_runt,
  output logic [LEN_WIDTH-1:0] frame_count
);

  typedef enum logic [0:0] {IDLE = 1'b0, FRAME = 1'b1} state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_MAX   = {LEN_WIDTH{1'b1}};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE   = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] MIN_LEN_L = LEN_WIDTH'(MIN_LEN);

  (* IOB = "TRUE" *) logic [WIDTH-1:0] cap_d_r;
  (* IOB = "TRUE" *) logic             cap_dv_r;

  logic [WIDTH-1:0]     last_d;
  logic                 last_dv;
  logic [WIDTH-1:0]     out_q_r;
  logic                 out_dv_r;
  logic                 out_sof_r;
  state_t               state_r;
  state_t               state_nxt;
  logic [LEN_WIDTH-1:0] len_cnt_r;
  logic [LEN_WIDTH-1:0] len_nxt;
  logic [LEN_WIDTH-1:0] len_hold_r;
  logic [LEN_WIDTH-1:0] frame_count_r;
  logic                 sof_nxt;
  logic                 eof_s;

  // Pin capture stage: pins feed the flops directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_d_r  <= '0;
      cap_dv_r <= 1'b0;
    end else begin
      cap_d_r  <= input_d;
      cap_dv_r <= input_dv;
    end
  end

  generate
    if (PIPE_DEPTH > 2) begin : g_dly
      logic [WIDTH-1:0] dly_d  [PIPE_DEPTH-2];
      logic             dly_dv [PIPE_DEPTH-2];

      // Extra delay stages between capture and output register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < PIPE_DEPTH-2; i++) begin
            dly_d[i]  <= '0;
            dly_dv[i] <= 1'b0;
          end
        end else begin
          dly_d[0]  <= cap_d_r;
          dly_dv[0] <= cap_dv_r;
          for (int i = 1; i < PIPE_DEPTH-2; i++) begin
            dly_d[i]  <= dly_d[i-1];
            dly_dv[i] <= dly_dv[i-1];
          end
        end
      end

      assign last_d  = dly_d[PIPE_DEPTH-3];
      assign last_dv = dly_dv[PIPE_DEPTH-3];
    end else begin : g_nodly
      assign last_d  = cap_d_r;
      assign last_dv = cap_dv_r;
    end
  endgenerate

  // The word behind the output register is the look-ahead, so eof/len/runt
  // are decoded from registers in the same cycle the last word is presented.
  always_comb begin
    state_nxt = state_r;
    len_nxt   = len_cnt_r;
    eof_s     = out_dv_r & ~last_dv;
    sof_nxt   = last_dv & ((state_r == IDLE) | ~out_dv_r);
    if (last_dv) begin
      if (sof_nxt) begin
        len_nxt = LEN_ONE;
      end else if (len_cnt_r != LEN_MAX) begin
        len_nxt = len_cnt_r + LEN_ONE;
      end else begin
        len_nxt = len_cnt_r;
      end
    end else begin
      len_nxt = len_cnt_r;
    end
    case (state_r)
      IDLE:    state_nxt = last_dv ? FRAME : IDLE;
      FRAME:   state_nxt = eof_s ? IDLE : FRAME;
      default: state_nxt = IDLE;
    endcase
  end

  // Output register, framing state and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q_r       <= '0;
      out_dv_r      <= 1'b0;
      out_sof_r     <= 1'b0;
      state_r       <= IDLE;
      len_cnt_r     <= '0;
      len_hold_r    <= '0;
      frame_count_r <= '0;
    end else begin
      out_q_r   <= last_d;
      out_dv_r  <= last_dv;
      out_sof_r <= sof_nxt;
      state_r   <= state_nxt;
      len_cnt_r <= len_nxt;
      if (eof_s) begin
        len_hold_r    <= len_cnt_r;
        frame_count_r <= frame_count_r + LEN_ONE;
      end else begin
        len_hold_r    <= len_hold_r;
        frame_count_r <= frame_count_r;
      end
    end
  end

  assign output_clk  = clk;
  assign output_q    = out_q_r;
  assign output_dv   = out_dv_r;
  assign output_sof  = out_sof_r;
  assign output_eof  = eof_s;
  assign output_len  = eof_s ? len_cnt_r : len_hold_r;
  assign output_runt = eof_s & (len_cnt_r < MIN_LEN_L);
  assign frame_count = frame_count_r;

endmodule

// File: tb/tb_ssio_sdr_in_framer.sv
// Scoreboard bench: three framer configurations (defaults, PIPE_DEPTH=5,
// LEN_WIDTH=4) share one stimulus stream; a monitor checks each output word.
module tb_ssio_sdr_in_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] input_d;
  logic       input_dv;

  logic        oclk_a, dv_a, sof_a, eof_a, runt_a;
  logic [7:0]  q_a;
  logic [15:0] len_a, fc_a;
  logic        oclk_b, dv_b, sof_b, eof_b, runt_b;
  logic [7:0]  q_b;
  logic [15:0] len_b, fc_b;
  logic        oclk_c, dv_c, sof_c, eof_c, runt_c;
  logic [7:0]  q_c;
  logic [3:0]  len_c, fc_c;

  ssio_sdr_in_framer u_a (
    .clk(clk), .rst_n(rst_n), .input_d(input_d), .input_dv(input_dv),
    .output_clk(oclk_a), .output_q(q_a), .output_dv(dv_a), .output_sof(sof_a),
    .output_eof(eof_a), .output_len(len_a), .output_runt(runt_a), .frame_count(fc_a));

  ssio_sdr_in_framer #(.PIPE_DEPTH(5)) u_b (
    .clk(clk), .rst_n(rst_n), .input_d(input_d), .input_dv(input_dv),
    .output_clk(oclk_b), .output_q(q_b), .output_dv(dv_b), .output_sof(sof_b),
    .output_eof(eof_b), .output_len(len_b), .output_runt(runt_b), .frame_count(fc_b));

  ssio_sdr_in_framer #(.LEN_WIDTH(4)) u_c (
    .clk(clk), .rst_n(rst_n), .input_d(input_d), .input_dv(input_dv),
    .output_clk(oclk_c), .output_q(q_c), .output_dv(dv_c), .output_sof(sof_c),
    .output_eof(eof_c), .output_len(len_c), .output_runt(runt_c), .frame_count(fc_c));

  typedef struct {
    logic [7:0] q;
    logic       sof;
    logic       eof;
    int         len;
    logic       runt;
    int         fc;
    int         edge_n;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  int pd[3]   = '{2, 5, 2};
  int lmax[3] = '{65535, 65535, 15};
  int fc_m[3] = '{0, 0, 0};
  int edge_cnt = 0;
  int ntot = 0;
  int nfail = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input int k, input longint act, input longint exp);
    ntot++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s inst=%0d got=%0d want=%0d t=%0t", name, k, act, exp, $time);
    end
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic sof, input logic eof, input int cnt);
    exp_t e;
    e.q      = d;
    e.sof    = sof;
    e.eof    = eof;
    e.len    = (cnt > lmax[k]) ? lmax[k] : cnt;
    e.runt   = eof && (e.len < 4);
    e.fc     = fc_m[k];
    e.edge_n = edge_cnt + pd[k];
    if (eof) fc_m[k] = (fc_m[k] + 1) % (lmax[k] + 1);
    case (k)
      0:       qa.push_back(e);
      1:       qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  task automatic mon(input int k, input logic dv, input logic [7:0] q, input logic sof,
                     input logic eof, input int len, input logic runt, input int fc);
    exp_t e;
    bit   got;
    got = 1'b0;
    if (!dv) begin
      chk("eof_without_dv", k, eof, 0);
    end else begin
      case (k)
        0:       if (qa.size() > 0) begin e = qa.pop_front(); got = 1'b1; end
        1:       if (qb.size() > 0) begin e = qb.pop_front(); got = 1'b1; end
        default: if (qc.size() > 0) begin e = qc.pop_front(); got = 1'b1; end
      endcase
      if (!got) begin
        ntot++;
        nfail++;
        $display("FAIL unexpected_word inst=%0d got q=%0h want=none t=%0t", k, q, $time);
      end else begin
        chk("q", k, q, e.q);
        chk("latency_edge", k, edge_cnt, e.edge_n);
        chk("sof", k, sof, e.sof);
        chk("eof", k, eof, e.eof);
        chk("runt", k, runt, e.runt);
        if (e.eof) begin
          chk("len", k, len, e.len);
          chk("frame_count_at_eof", k, fc, e.fc);
        end
      end
    end
  endtask

  // Monitor samples 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    mon(0, dv_a, q_a, sof_a, eof_a, int'(len_a), runt_a, int'(fc_a));
    mon(1, dv_b, q_b, sof_b, eof_b, int'(len_b), runt_b, int'(fc_b));
    mon(2, dv_c, q_c, sof_c, eof_c, int'(len_c), runt_c, int'(fc_c));
  end

  task automatic check_reset_state(input string name);
    chk({name, "_dv"},   0, {dv_a, dv_b, dv_c}, 0);
    chk({name, "_q"},    0, {q_a, q_b, q_c}, 0);
    chk({name, "_sof"},  0, {sof_a, sof_b, sof_c}, 0);
    chk({name, "_eof"},  0, {eof_a, eof_b, eof_c}, 0);
    chk({name, "_len"},  0, {len_a, len_b, len_c}, 0);
    chk({name, "_runt"}, 0, {runt_a, runt_b, runt_c}, 0);
    chk({name, "_fc"},   0, {fc_a, fc_b, fc_c}, 0);
    chk({name, "_clk"},  0, {oclk_a, oclk_b, oclk_c}, {3{clk}});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      input_dv = 1'b0;
    end
  endtask

  // rst_at < n asserts reset in place of word rst_at and abandons the frame.
  task automatic send_frame(input int n, input logic [7:0] base, input int gap, input int rst_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == rst_at) begin
        rst_n    = 1'b0;
        input_dv = 1'b0;
        #1;
        check_reset_state("mid_reset");
        qa.delete();
        qb.delete();
        qc.delete();
        for (int k = 0; k < 3; k++) fc_m[k] = 0;
        repeat (2) @(negedge clk);
        return;
      end
      rst_n    = 1'b1;
      input_d  = base + 8'(i);
      input_dv = 1'b1;
      for (int k = 0; k < 3; k++) push(k, input_d, i == 0, i == n - 1, i + 1);
    end
    idle(gap);
  endtask

  initial begin
    int t;
    rst_n    = 1'b0;
    input_d  = 8'h00;
    input_dv = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_state("reset");

    send_frame(6, 8'h01, 3, -1);   // 0x01..0x06, runt=0
    send_frame(1, 8'hAA, 3, -1);   // single word, sof=eof, runt=1
    send_frame(3, 8'h10, 1, -1);   // back-to-back with one idle cycle
    send_frame(5, 8'h20, 8, -1);
    send_frame(8, 8'h30, 0, 2);    // reset at word 3 of 8
    send_frame(4, 8'h40, 3, -1);   // dv already high at reset release
    send_frame(20, 8'h50, 8, -1);  // saturates in the LEN_WIDTH=4 instance

    @(negedge clk);
    input_d  = 8'h5A;
    input_dv = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("q_passthrough_dv0", 0, q_a, 8'h5A);
    chk("q_passthrough_dv0", 1, q_b, 8'h5A);
    chk("q_passthrough_dv0", 2, q_c, 8'h5A);
    chk("len_hold", 0, len_a, 20);
    chk("len_hold", 2, len_c, 15);

    t = 0;
    while ((qa.size() + qb.size() + qc.size()) != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("scoreboard_drained", 0, qa.size() + qb.size() + qc.size(), 0);
    chk("frame_count_final", 0, fc_a, fc_m[0]);
    chk("frame_count_final", 1, fc_b, fc_m[1]);
    chk("frame_count_final", 2, fc_c, fc_m[2]);

    $display("test done: total=%0d bad=%0d", ntot, nfail);
    $finish;
  end

endmodule
